// File: rtl/serial_deserializer.sv
// serial_deserializer: collects an LSB-first bit stream into WIDTH-bit words
// and presents each word on a valid/ready port through one holding register.
// A start bit that interrupts a partial word raises a one-cycle frame error.
// A word that completes while the holding register is still full is dropped,
// and this sets a sticky overflow flag.
module serial_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_bit_in,
  input  logic             i_bit_valid,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_word_out,
  output logic             o_word_valid,
  input  logic             i_word_ready,
  output logic             o_frame_err,
  output logic             o_overflow,
  input  logic             i_clr_ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_sr, w_sr_next;
  logic [WIDTH-1:0] r_hold, w_hold_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic             r_word_valid, w_word_valid_next;
  logic             r_frame_err, w_frame_err_next;
  logic             r_overflow, w_overflow_next;
  logic             w_complete, w_load, w_consume;
  logic [WIDTH-1:0] w_shifted;

  // New bits enter at the MSB, so bit 0 ends up at the LSB after WIDTH shifts
  assign w_shifted = {i_bit_in, r_sr[WIDTH-1:1]};

  // Next-state logic for the FSM, the shift datapath, the holding register and the flags
  always_comb begin
    w_state_next      = r_state;
    w_sr_next         = r_sr;
    w_cnt_next        = r_cnt;
    w_hold_next       = r_hold;
    w_word_valid_next = r_word_valid;
    w_frame_err_next  = 1'b0;
    w_overflow_next   = r_overflow;
    w_complete        = 1'b0;
    w_load            = 1'b0;
    w_consume         = r_word_valid && i_word_ready;

    case (r_state)
      S_IDLE: begin
        // Bits that arrive without start are ignored here, and no error is raised
        if (i_bit_valid && i_start) begin
          w_sr_next    = w_shifted;
          w_cnt_next   = CW'(1);
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (i_bit_valid) begin
          if (i_start) begin
            // Start has priority, even on what would be the last bit
            w_sr_next        = w_shifted;
            w_cnt_next       = CW'(1);
            w_frame_err_next = 1'b1;
          end else if (r_cnt == CW'(WIDTH - 1)) begin
            w_complete   = 1'b1;
            w_sr_next    = w_shifted;
            w_cnt_next   = '0;
            w_state_next = S_IDLE;
          end else begin
            w_sr_next  = w_shifted;
            w_cnt_next = r_cnt + CW'(1);
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // The holding register can take a word when it is empty or being drained this edge
    w_load = w_complete && (!r_word_valid || i_word_ready);

    if (w_load) begin
      w_hold_next       = w_shifted;
      w_word_valid_next = 1'b1;
    end else if (w_consume) begin
      w_word_valid_next = 1'b0;
    end

    // When a word is dropped on the same edge as a clear, the set wins
    if (w_complete && !w_load) begin
      w_overflow_next = 1'b1;
    end else if (i_clr_ovf) begin
      w_overflow_next = 1'b0;
    end
  end

  // State register. Reset discards any partial word without raising an error
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_sr         <= '0;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_sr         <= w_sr_next;
      r_cnt        <= w_cnt_next;
      r_hold       <= w_hold_next;
      r_word_valid <= w_word_valid_next;
      r_frame_err  <= w_frame_err_next;
      r_overflow   <= w_overflow_next;
    end
  end

  assign o_word_out   = r_hold;
  assign o_word_valid = r_word_valid;
  assign o_frame_err  = r_frame_err;
  assign o_overflow   = r_overflow;

endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Receive-side companion to the bit-serial datapath: collects an LSB-first bit stream, such as the sum output of the serial adder, into parallel words of WIDTH bits. Each completed word is presented on a valid/ready output port backed by one holding register, so the next word can shift in while the previous one waits. Frame errors and words dropped on overflow are reported to the surrounding control logic.

## Interface
- WIDTH, 8: bits per word; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low. While low, all state is cleared.
- bit_in  in  1  serial data bit, LSB first.
- bit_valid  in  1  bit_in is sampled at this edge.
- start  in  1  qualified by bit_valid; marks bit_in as bit 0 of a new word.
- word_out  out  WIDTH  assembled word (holding register).
- word_valid  out  1  word_out holds an unconsumed word.
- word_ready  in  1  consumer accepts word_out this edge.
- frame_err  out  1  one-cycle pulse: a partial word was aborted by start.
- overflow  out  1  sticky: a completed word was dropped. Cleared by clr_ovf or reset.
- clr_ovf  in  1  clears overflow. Set wins if both occur on the same edge.

## Operation
- Datapath: WIDTH-bit shift register `sr`, inserting at the MSB and shifting right. Bit counter `cnt`, width clog2(WIDTH)+1. Output holding register `hold` plus `word_valid`.
- FSM states: IDLE, SHIFT.
  - **IDLE:**
    - `bit_valid` && `start`: load the bit, set `cnt`=1, go to SHIFT.
    - `bit_valid` without `start`: the bit is ignored, with no error.
  - **SHIFT**, on `bit_valid`:
    - Without `start`: shift in the bit and increment `cnt`.
    - With `start`: discard the partial word, pulse `frame_err`, and restart with `cnt`=1 (this bit is bit 0). The state stays SHIFT.
  - **SHIFT, word completion:** when the WIDTH-th bit is sampled, the completed word is `{bit_in, sr[WIDTH-1:1]}`. The FSM returns to IDLE.
    - Holding register free (`!word_valid`) or being drained this edge (`word_valid && word_ready`): load `hold`, `word_valid`=1.
    - Otherwise: drop the word, set `overflow`, leave `hold` untouched.
  - **Completion with start:** if `start` arrives with what would be the WIDTH-th bit, `start` takes priority. There is no completion and `frame_err` pulses.
- **Output handshake:**
  - `word_valid && word_ready` at an edge consumes the word.
  - `word_valid` falls unless a new word loads on the same edge.
  - `word_out` is stable while `word_valid && !word_ready`.
- **Bubbles:** `bit_valid` low in SHIFT holds all state. There is no timeout.
- **Reset:** all values are cleared and the FSM returns to IDLE. A reset mid-word discards the partial word silently, with no `frame_err`.

## Timing
- **Reset values:** `word_out`=0, `word_valid`=0, `frame_err`=0, `overflow`=0, state IDLE, `cnt`=0, `sr`=0.
- **Latency:** the last bit sampled at edge k gives `word_valid`=1 and a valid `word_out` after edge k. Total latency is WIDTH bit-cycles from bit 0 to `word_valid`.
- **Throughput:** back-to-back words, one bit per cycle, with no dead cycle between frames when `start` accompanies the bit following the previous word's last bit.
- **Timing of the error flags:**
  - `frame_err` is high for exactly one cycle, the cycle after the aborting edge.
  - `overflow` is set on the edge after the dropped completion.
- **Registered outputs:** all outputs are registers, with no combinational path from inputs to outputs.

## Test plan
- **Basic word:** WIDTH=8, `word_ready`=1, `start` on the first bit, stream LSB-first bits 1,1,0,1,0,0,1,1 on consecutive cycles.
  -> `word_out`=8'hCB, `word_valid` high one cycle after the 8th bit, then low.
- **Backpressure and overflow:**
  - Send word A=8'h5A with `word_ready`=0.
  - Immediately send word B=8'h3C.
  - -> `word_out` stays 8'h5A, `overflow`=1 after B's last bit.
  - Raise `word_ready` -> 8'h5A consumed, `word_valid`=0.
  - Pulse `clr_ovf` -> `overflow`=0.
- **Drain and load on the same edge:** complete word B on the exact edge word A is consumed.
  - -> `word_valid` stays 1, `word_out` changes from A to B, `overflow`=0.
- **Frame resync:** 3 bits of a word, then `start` with a new 8-bit word 8'hF0.
  - -> `frame_err` one-cycle pulse, `word_out`=8'hF0 after 8 more bits.
- **Bubbles and IDLE ignore:**
  - `bit_valid` pulses without `start` in IDLE -> no state change.
  - Word 8'h81 with `bit_valid` low every other cycle -> `word_out`=8'h81 after the 8th valid bit.
- **Async reset mid-word:** assert `rst` low between clock edges after 4 bits.
  - -> outputs clear immediately, no `frame_err`.
  - A fresh word 8'h0F after deassertion is received correctly.
